pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three event sources: load-use hazards, taken branches, and multi-cycle data-memory accesses. It also owns the data-memory request handshake, a wait-timeout watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/dmem_wait_fsm.sv | 74 +++++++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by the controller top and its memory-wait sub-module.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      M_IDLE,
      M_WAIT,
      M_ERR
   } mem_state_t;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   function automatic logic load_use(
      input logic             mem_read,
      input logic [REG_W-1:0] rt_ex,
      input logic [REG_W-1:0] rs_id,
      input logic [REG_W-1:0] rt_id
   );
      return mem_read && (rt_ex != REG_ZERO) &&
             ((rt_ex == rs_id) || (rt_ex == rt_id));
   endfunction

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory request handshake with wait counter and timeout watchdog.
// M_ERR is sticky and can only be left through rst.
module dmem_wait_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access,
   input  logic dmem_ready,
   output logic dmem_req,
   output logic mem_busy,
   output logic timeout_err
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   mem_state_t state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   // State and wait counter registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= M_IDLE;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next state and handshake outputs; completion beats the timeout.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      dmem_req    = 1'b0;
      mem_busy    = 1'b0;
      timeout_err = 1'b0;
      case (state_q)
         M_IDLE: begin
            if (mem_access) begin
               dmem_req = 1'b1;
               if (!dmem_ready) begin
                  state_d    = M_WAIT;
                  wait_cnt_d = 8'd0;
               end
            end
         end
         M_WAIT: begin
            dmem_req = 1'b1;
            mem_busy = 1'b1;
            if (dmem_ready) begin
               state_d = M_IDLE;
            end else if (wait_cnt_q == LAST) begin
               state_d = M_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         M_ERR: begin
            timeout_err = 1'b1;
         end
         default: begin
            state_d = M_IDLE;
         end
      endcase
      if (rst) begin
         dmem_req = 1'b0;
         mem_busy = 1'b0;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Resolves memory waits, taken branches and load-use hazards by priority.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cycles
);

   logic             hazard;
   logic [CNT_W-1:0] stall_q, stall_d;

   dmem_wait_fsm #(
      .TIMEOUT(TIMEOUT)
   ) u_wait (
      .clk        (clk),
      .rst        (rst),
      .mem_access (mem_access),
      .dmem_ready (dmem_ready),
      .dmem_req   (dmem_req),
      .mem_busy   (mem_busy),
      .timeout_err(timeout_err)
   );

   assign hazard = load_use(ex_mem_read, ex_rt, id_rs, id_rt);

   // Priority mux: reset > error > memory wait > branch > load-use.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (timeout_err) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (mem_busy) begin
         if (!dmem_ready) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
         end
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hazard) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_comb begin
      stall_d = stall_q;
      if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a behavioural model.
// Uses TIMEOUT=4 and a 4-bit stall counter so saturation is reachable.
module tb_pipe_ctrl;

   localparam int TMO = 4;
   localparam int CW  = 4;
   localparam int SAT = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
   logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
   logic          mem_access = 1'b0, dmem_ready = 1'b0;
   logic          dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_busy, timeout_err;
   logic [CW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   // model state: waited = -1 when no access is outstanding,
   // otherwise the number of wait cycles already completed
   int waited = -1;
   bit failed = 0;
   int stalls = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en),
      .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
      .mem_busy(mem_busy), .timeout_err(timeout_err),
      .stall_cycles(stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [10:0] outs();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
              if_id_flush, id_ex_flush, mem_wb_flush,
              dmem_req, mem_busy, timeout_err};
   endfunction

   // expected {5 enables, 3 flushes, req, busy, err} from the rules
   function automatic logic [10:0] expect_outs();
      bit haz;
      haz = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
      if (rst)
         return 11'b00000_111_000;
      if (failed)
         return 11'b00000_000_001;
      if (waited >= 0) begin
         if (dmem_ready)
            return 11'b11111_000_110;
         return 11'b00001_001_110;
      end
      if (ex_branch_taken)
         return {5'b11111, 3'b110, mem_access, 2'b00};
      if (haz)
         return {5'b00111, 3'b010, mem_access, 2'b00};
      return {5'b11111, 3'b000, mem_access, 2'b00};
   endfunction

   task automatic step(input bit r, input bit acc, input bit rdy,
                       input bit rd, input bit br, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] ert);
      logic [10:0] e;
      @(negedge clk);
      rst = r; mem_access = acc; dmem_ready = rdy;
      ex_mem_read = rd; ex_branch_taken = br;
      id_rs = rs; id_rt = rt; ex_rt = ert;
      #1;
      if (r) begin
         waited = -1; failed = 0; stalls = 0;
      end
      e = expect_outs();
      chk("ctl", 32'(outs()), 32'(e));
      chk("stall", 32'(stall_cycles), 32'(stalls));
      @(posedge clk);
      if (!r) begin
         if (!e[10] && stalls < SAT) stalls++;
         if (failed) begin
         end else if (waited >= 0) begin
            if (rdy) waited = -1;
            else if (waited + 1 == TMO) failed = 1;
            else waited++;
         end else if (acc && !rdy) begin
            waited = 0;
         end
      end
   endtask

   function automatic logic [4:0] pick();
      logic [4:0] r;
      case ($urandom_range(0, 3))
         0: r = 5'd0;
         1: r = 5'd8;
         2: r = 5'd9;
         default: r = 5'd17;
      endcase
      return r;
   endfunction

   initial begin
      // reset state
      step(1, 1, 0, 1, 1, 8, 8, 8);
      chk("rst_req", 32'(dmem_req), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // load-use: one stall cycle, counted once
      step(0, 0, 0, 1, 0, 8, 3, 8);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_cnt", 32'(stall_cycles), 1);
      // load into r0 never stalls
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_r0", 32'(stall_cycles), 1);

      // branch masks a simultaneous load-use
      step(0, 0, 0, 1, 1, 8, 8, 8);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("br_cnt", 32'(stall_cycles), 1);

      // memory wait released in the third wait cycle
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0, 8, 8, 8);
      step(0, 1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("mw_cnt", 32'(stall_cycles), 3);
      chk("mw_idle", 32'(mem_busy), 0);

      // completion in the final allowed wait cycle
      step(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < TMO - 1; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("bnd_err", 32'(timeout_err), 0);

      // timeout, then error persists and the counter saturates
      step(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < TMO; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 1, 0, 0, 0);
      chk("tmo_err", 32'(timeout_err), 1);
      chk("sat", 32'(stall_cycles), SAT);

      // asynchronous reset in the middle of a wait
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("ar_req", 32'(dmem_req), 0);
      chk("ar_flush", 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 7);
      chk("ar_busy", 32'(mem_busy), 0);
      chk("ar_cnt", 32'(stall_cycles), 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("ar_resume", 32'(pc_en), 1);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 39) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0,
              pick(), pick(), pick());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
